// File: rtl/memory_pkg.sv
// Shared definitions for the Beta memory-access stage: opcodes used by the
// stage, the canonical NOP instruction and the memory-stage state encoding.
package memory_pkg;

    localparam logic [5:0] OPCODE_ADD = 6'h20;
    localparam logic [5:0] OPCODE_LD  = 6'h18;
    localparam logic [5:0] OPCODE_ST  = 6'h19;
    localparam logic [5:0] OPCODE_LDR = 6'h1F;

    // ADD R31, R31, R31: writes nothing, used as the pipeline bubble
    localparam logic [31:0] IR_NOP = {OPCODE_ADD, 5'd31, 5'd31, 5'd31, 11'd0};

    localparam logic [0:0] MEM_IDLE = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

endpackage

// File: rtl/memory_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory (slave).
interface memory_if #(
    parameter int AW = 32
) ();

    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [31:0]   dmem_rdata;
    logic          dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/memory_mem_op_decode.sv
// Classifies an instruction opcode as a data-memory read (LD/LDR),
// a data-memory write (ST), or neither.
module memory_mem_op_decode
    import memory_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_read,
    output logic       is_write
);

    // Pure opcode compare; every other opcode is a passthrough instruction
    always_comb begin
        is_read  = (opcode == OPCODE_LD) || (opcode == OPCODE_LDR);
        is_write = (opcode == OPCODE_ST);
    end

endmodule

// File: rtl/memory.sv
// Beta memory-access stage. Issues LD/LDR/ST to data memory over a req/ack
// bus, stalls upstream while an access is outstanding, and registers the
// pc/ir/y triple toward writeback, substituting a NOP bubble while waiting.
module memory
    import memory_pkg::*;
#(
    parameter int AW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc_mem_next,
    input  logic [31:0]      ir_mem_next,
    input  logic [31:0]      y_mem_next,
    input  logic [31:0]      st_mem_next,
    output logic             stall_mem,
    memory_if.master         dmem,
    output logic [31:0]      pc_wb_next,
    output logic [31:0]      ir_wb_next,
    output logic [31:0]      y_wb_next,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]  state;
    logic [31:0] hold_pc;
    logic [31:0] hold_ir;
    logic [31:0] hold_y;
    logic [31:0] hold_st;

    logic [31:0] sel_pc;
    logic [31:0] sel_ir;
    logic [31:0] sel_y;
    logic [31:0] sel_st;
    logic        is_read;
    logic        is_write;
    logic        req;

    // While waiting the held instruction owns the bus; otherwise the live input does
    always_comb begin
        if (state == MEM_WAIT) begin
            sel_pc = hold_pc;
            sel_ir = hold_ir;
            sel_y  = hold_y;
            sel_st = hold_st;
        end else begin
            sel_pc = pc_mem_next;
            sel_ir = ir_mem_next;
            sel_y  = y_mem_next;
            sel_st = st_mem_next;
        end
    end

    memory_mem_op_decode u_decode (
        .opcode   (sel_ir[31:26]),
        .is_read  (is_read),
        .is_write (is_write)
    );

    // Request is gated by reset so an abandoned access drops in the same cycle
    always_comb begin
        req             = rst_n && (is_read || is_write);
        dmem.dmem_req   = req;
        dmem.dmem_we    = is_write;
        dmem.dmem_addr  = {sel_y[AW-1:2], 2'b00};
        dmem.dmem_wdata = sel_st;
        stall_mem       = req && !dmem.dmem_ack;
    end

    // Pipeline register, hold registers, FSM and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= MEM_IDLE;
            pc_wb_next  <= 32'd0;
            ir_wb_next  <= IR_NOP;
            y_wb_next   <= 32'd0;
            stall_count <= '0;
            hold_pc     <= 32'd0;
            hold_ir     <= 32'd0;
            hold_y      <= 32'd0;
            hold_st     <= 32'd0;
        end else begin
            if (stall_mem && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_ONE;
            end
            if (!req) begin
                pc_wb_next <= pc_mem_next;
                ir_wb_next <= ir_mem_next;
                y_wb_next  <= y_mem_next;
                state      <= MEM_IDLE;
            end else if (dmem.dmem_ack) begin
                pc_wb_next <= sel_pc;
                ir_wb_next <= sel_ir;
                y_wb_next  <= is_read ? dmem.dmem_rdata : sel_y;
                state      <= MEM_IDLE;
            end else begin
                pc_wb_next <= 32'd0;
                ir_wb_next <= IR_NOP;
                y_wb_next  <= 32'd0;
                hold_pc    <= sel_pc;
                hold_ir    <= sel_ir;
                hold_y     <= sel_y;
                hold_st    <= sel_st;
                state      <= MEM_WAIT;
            end
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed bench for the memory stage: passthrough, zero-wait load,
// multi-cycle store, back-to-back flow, reset mid-access and counter saturation.
module tb_memory;

    localparam logic [31:0] NOP    = 32'h83FF_F800;
    localparam logic [31:0] IR_ADD = {6'h20, 5'd1, 5'd2, 5'd3, 11'd0};
    localparam logic [31:0] IR_LD  = {6'h18, 5'd4, 5'd5, 16'h0000};
    localparam logic [31:0] IR_ST  = {6'h19, 5'd6, 5'd7, 16'h0000};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_mem_next, ir_mem_next, y_mem_next, st_mem_next;
    logic        stall_mem, stall_mem_sat;
    logic [31:0] pc_wb_next, ir_wb_next, y_wb_next;
    logic [31:0] pc_wb_sat, ir_wb_sat, y_wb_sat;
    logic [31:0] stall_count;
    logic [3:0]  stall_count_sat;

    int n_checks = 0;
    int n_pass   = 0;

    memory_if #(.AW(32)) bus ();
    memory_if #(.AW(32)) sat_bus ();

    memory #(.AW(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_mem_next(pc_mem_next), .ir_mem_next(ir_mem_next),
        .y_mem_next(y_mem_next), .st_mem_next(st_mem_next),
        .stall_mem(stall_mem), .dmem(bus.master),
        .pc_wb_next(pc_wb_next), .ir_wb_next(ir_wb_next),
        .y_wb_next(y_wb_next), .stall_count(stall_count)
    );

    memory #(.AW(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .pc_mem_next(pc_mem_next), .ir_mem_next(ir_mem_next),
        .y_mem_next(y_mem_next), .st_mem_next(st_mem_next),
        .stall_mem(stall_mem_sat), .dmem(sat_bus.master),
        .pc_wb_next(pc_wb_sat), .ir_wb_next(ir_wb_sat),
        .y_wb_next(y_wb_sat), .stall_count(stall_count_sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ir,
                         input logic [31:0] y, input logic [31:0] st);
        pc_mem_next = pc;
        ir_mem_next = ir;
        y_mem_next  = y;
        st_mem_next = st;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h0;
        sat_bus.dmem_ack = 1'b0;
        sat_bus.dmem_rdata = 32'h0;
        drive(32'h50, IR_LD, 32'h80, 32'h1);
        tick();
        tick();
        #1;
        n_checks++; if (ir_wb_next !== NOP) $display("[TB] FAIL reset_ir got %h exp %h", ir_wb_next, NOP); else n_pass++;
        n_checks++; if (pc_wb_next !== 32'h0) $display("[TB] FAIL reset_pc got %h exp 0", pc_wb_next); else n_pass++;
        n_checks++; if (y_wb_next !== 32'h0) $display("[TB] FAIL reset_y got %h exp 0", y_wb_next); else n_pass++;
        n_checks++; if (stall_count !== 32'h0) $display("[TB] FAIL reset_count got %0d exp 0", stall_count); else n_pass++;
        n_checks++; if (bus.dmem_req !== 1'b0) $display("[TB] FAIL reset_req got %b exp 0", bus.dmem_req); else n_pass++;
        n_checks++; if (stall_mem !== 1'b0) $display("[TB] FAIL reset_stall got %b exp 0", stall_mem); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        drive(32'h100, IR_ADD, 32'h3, 32'h0);
        #1;
        n_checks++; if (stall_mem !== 1'b0) $display("[TB] FAIL pass_stall got %b exp 0", stall_mem); else n_pass++;
        n_checks++; if (bus.dmem_req !== 1'b0) $display("[TB] FAIL pass_req got %b exp 0", bus.dmem_req); else n_pass++;
        tick();
        n_checks++; if (pc_wb_next !== 32'h100) $display("[TB] FAIL pass_pc got %h exp 100", pc_wb_next); else n_pass++;
        n_checks++; if (ir_wb_next !== IR_ADD) $display("[TB] FAIL pass_ir got %h exp %h", ir_wb_next, IR_ADD); else n_pass++;
        n_checks++; if (y_wb_next !== 32'h3) $display("[TB] FAIL pass_y got %h exp 3", y_wb_next); else n_pass++;
    endtask

    task automatic test_zero_wait_load();
        drive(32'h104, IR_LD, 32'h207, 32'h0);
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (bus.dmem_req !== 1'b1) $display("[TB] FAIL zw_req got %b exp 1", bus.dmem_req); else n_pass++;
        n_checks++; if (bus.dmem_we !== 1'b0) $display("[TB] FAIL zw_we got %b exp 0", bus.dmem_we); else n_pass++;
        n_checks++; if (bus.dmem_addr !== 32'h204) $display("[TB] FAIL zw_addr got %h exp 204", bus.dmem_addr); else n_pass++;
        n_checks++; if (stall_mem !== 1'b0) $display("[TB] FAIL zw_stall got %b exp 0", stall_mem); else n_pass++;
        tick();
        bus.dmem_ack = 1'b0;
        drive(32'h108, IR_ADD, 32'h5, 32'h0);
        n_checks++; if (y_wb_next !== 32'hDEADBEEF) $display("[TB] FAIL zw_y got %h exp deadbeef", y_wb_next); else n_pass++;
        n_checks++; if (ir_wb_next !== IR_LD) $display("[TB] FAIL zw_ir got %h exp %h", ir_wb_next, IR_LD); else n_pass++;
        n_checks++; if (pc_wb_next !== 32'h104) $display("[TB] FAIL zw_pc got %h exp 104", pc_wb_next); else n_pass++;
        n_checks++; if (stall_count !== 32'd0) $display("[TB] FAIL zw_count got %0d exp 0", stall_count); else n_pass++;
    endtask

    task automatic test_multi_cycle_store();
        drive(32'h10C, IR_ST, 32'h40, 32'h55);
        bus.dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (stall_mem !== 1'b1) $display("[TB] FAIL st_stall[%0d] got %b exp 1", i, stall_mem); else n_pass++;
            n_checks++; if (bus.dmem_addr !== 32'h40) $display("[TB] FAIL st_addr[%0d] got %h exp 40", i, bus.dmem_addr); else n_pass++;
            n_checks++; if (bus.dmem_wdata !== 32'h55) $display("[TB] FAIL st_wdata[%0d] got %h exp 55", i, bus.dmem_wdata); else n_pass++;
            n_checks++; if (bus.dmem_we !== 1'b1) $display("[TB] FAIL st_we[%0d] got %b exp 1", i, bus.dmem_we); else n_pass++;
            tick();
            n_checks++; if (ir_wb_next !== NOP) $display("[TB] FAIL st_bubble[%0d] got %h exp %h", i, ir_wb_next, NOP); else n_pass++;
            drive(32'h10C, IR_ST, 32'h999, 32'h77);
        end
        bus.dmem_ack = 1'b1;
        #1;
        n_checks++; if (stall_mem !== 1'b0) $display("[TB] FAIL st_ack_stall got %b exp 0", stall_mem); else n_pass++;
        n_checks++; if (bus.dmem_addr !== 32'h40) $display("[TB] FAIL st_ack_addr got %h exp 40", bus.dmem_addr); else n_pass++;
        tick();
        bus.dmem_ack = 1'b0;
        drive(32'h110, IR_ADD, 32'h6, 32'h0);
        n_checks++; if (ir_wb_next !== IR_ST) $display("[TB] FAIL st_ir got %h exp %h", ir_wb_next, IR_ST); else n_pass++;
        n_checks++; if (y_wb_next !== 32'h40) $display("[TB] FAIL st_y got %h exp 40", y_wb_next); else n_pass++;
        n_checks++; if (pc_wb_next !== 32'h10C) $display("[TB] FAIL st_pc got %h exp 10c", pc_wb_next); else n_pass++;
        n_checks++; if (stall_count !== 32'd3) $display("[TB] FAIL st_count got %0d exp 3", stall_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(32'h200, IR_LD, 32'h300, 32'h0);
        bus.dmem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (ir_wb_next !== NOP) $display("[TB] FAIL b2b_bubble[%0d] got %h exp %h", i, ir_wb_next, NOP); else n_pass++;
        end
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h1234;
        tick();
        bus.dmem_ack = 1'b0;
        drive(32'h204, IR_ADD, 32'h11, 32'h0);
        n_checks++; if (ir_wb_next !== IR_LD) $display("[TB] FAIL b2b_ld_ir got %h exp %h", ir_wb_next, IR_LD); else n_pass++;
        n_checks++; if (y_wb_next !== 32'h1234) $display("[TB] FAIL b2b_ld_y got %h exp 1234", y_wb_next); else n_pass++;
        #1;
        n_checks++; if (bus.dmem_req !== 1'b0) $display("[TB] FAIL b2b_add_req got %b exp 0", bus.dmem_req); else n_pass++;
        tick();
        n_checks++; if (ir_wb_next !== IR_ADD) $display("[TB] FAIL b2b_add_ir got %h exp %h", ir_wb_next, IR_ADD); else n_pass++;
        n_checks++; if (pc_wb_next !== 32'h204) $display("[TB] FAIL b2b_add_pc got %h exp 204", pc_wb_next); else n_pass++;
        n_checks++; if (y_wb_next !== 32'h11) $display("[TB] FAIL b2b_add_y got %h exp 11", y_wb_next); else n_pass++;
        n_checks++; if (stall_count !== 32'd5) $display("[TB] FAIL b2b_count got %0d exp 5", stall_count); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        drive(32'h300, IR_LD, 32'h500, 32'h0);
        bus.dmem_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.dmem_req !== 1'b0) $display("[TB] FAIL rw_req got %b exp 0", bus.dmem_req); else n_pass++;
        n_checks++; if (stall_mem !== 1'b0) $display("[TB] FAIL rw_stall got %b exp 0", stall_mem); else n_pass++;
        tick();
        rst_n = 1'b1;
        drive(32'h400, IR_ADD, 32'h22, 32'h0);
        n_checks++; if (ir_wb_next !== NOP) $display("[TB] FAIL rw_ir got %h exp %h", ir_wb_next, NOP); else n_pass++;
        n_checks++; if (stall_count !== 32'd0) $display("[TB] FAIL rw_count got %0d exp 0", stall_count); else n_pass++;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hBAD0BAD0;
        #1;
        n_checks++; if (bus.dmem_req !== 1'b0) $display("[TB] FAIL rw_idle_req got %b exp 0", bus.dmem_req); else n_pass++;
        tick();
        bus.dmem_ack = 1'b0;
        n_checks++; if (ir_wb_next !== IR_ADD) $display("[TB] FAIL rw_add_ir got %h exp %h", ir_wb_next, IR_ADD); else n_pass++;
        n_checks++; if (y_wb_next !== 32'h22) $display("[TB] FAIL rw_add_y got %h exp 22", y_wb_next); else n_pass++;
    endtask

    task automatic test_saturation();
        drive(32'h500, IR_LD, 32'h600, 32'h0);
        bus.dmem_ack = 1'b0;
        sat_bus.dmem_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        n_checks++; if (stall_count_sat !== 4'd15) $display("[TB] FAIL sat_count got %0d exp 15", stall_count_sat); else n_pass++;
        n_checks++; if (stall_mem_sat !== 1'b1) $display("[TB] FAIL sat_stall got %b exp 1", stall_mem_sat); else n_pass++;
        n_checks++; if (stall_count !== 32'd20) $display("[TB] FAIL sat_wide_count got %0d exp 20", stall_count); else n_pass++;
        n_checks++; if (ir_wb_sat !== NOP) $display("[TB] FAIL sat_ir got %h exp %h", ir_wb_sat, NOP); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_zero_wait_load();
        test_multi_cycle_store();
        test_back_to_back();
        test_reset_in_wait();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Memory-access pipeline stage of the Beta CPU.
- Consumes the execute stage's outputs (pc/ir/y/st `*_mem_next`) and performs LD/LDR/ST against a data-memory port with a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Registers pc/ir/y toward writeback, inserting a NOP bubble during wait cycles.

Parameters:
- AW, 32, data-memory address width; `dmem_addr` = `{y[AW-1:2],2'b00}`.
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- pc_mem_next  in  32  PC+4 of instruction from execute
- ir_mem_next  in  32  instruction from execute
- y_mem_next  in  32  ALU result / effective address / link value
- st_mem_next  in  32  store data (Rc contents)
- stall_mem  out  1  high: upstream must hold its outputs this cycle
- dmem_req  out  1  data-memory request valid
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  AW  word-aligned address
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_ack  in  1  request accepted/completed this cycle
- pc_wb_next  out  32  registered PC to writeback
- ir_wb_next  out  32  registered instruction to writeback (NOP on bubble)
- y_wb_next  out  32  registered result: load data for LD/LDR, else y
- stall_count  out  CNT_W  saturating count of cycles with stall_mem=1

Behaviour:
- Memory op: opcode ∈ {`OPCODE_LD`, `OPCODE_LDR`, `OPCODE_ST`}.
  - LD/LDR is a read; ST is a write.
  - All other opcodes are passthrough.
- FSM states: IDLE, WAIT.

IDLE, input passthrough:
- dmem_req=0, stall_mem=0.
- Next edge: pc/ir/y_wb_next <= pc/ir/y_mem_next.
- Latency is 1 cycle.

IDLE, input memory op:
- Combinationally drives dmem_req=1, dmem_we=(ST), dmem_addr from y_mem_next, dmem_wdata=st_mem_next.
- dmem_ack=1 same cycle:
  - stall_mem=0.
  - Next edge: outputs load the instruction; y_wb_next = dmem_rdata for a read, y_mem_next for ST.
  - Remain IDLE.
- dmem_ack=0:
  - stall_mem=1.
  - Next edge: pc/ir/y/st captured into hold registers; ir_wb_next <= NOP, pc_wb_next/y_wb_next <= 0.
  - Go to WAIT.

WAIT:
- dmem_req=1; addr/we/wdata driven from hold registers, stable until ack.
- dmem_ack=0: stall_mem=1; outputs load bubble; stay WAIT.
- dmem_ack=1:
  - stall_mem=0, so upstream advances on this same edge.
  - Outputs load the held instruction with y = rdata (read) or held y (ST).
  - Go to IDLE.
- The new upstream instruction is not evaluated until the next cycle. No back-to-back overlap; at most one outstanding access.

Other rules:
- dmem_addr[1:0] is always 0; y[1:0] is ignored.
- NOP = `{OPCODE_ADD, 5'd31, 5'd31, 5'd31, 11'd0}`.
- stall_count increments each cycle stall_mem=1 and saturates at all-ones.
- ST passes its ir so writeback can decode it as no-write. This stage performs no register-write decision.

Reset (rst_n=0 at edge):
- state=IDLE, pc_wb_next=0, ir_wb_next=NOP, y_wb_next=0, stall_count=0, hold registers=0.
- While rst_n=0: dmem_req=0 and stall_mem=0, forced combinationally.
- Reset during WAIT abandons the access; dmem_req drops in that cycle. The memory side must tolerate a dropped request.
- dmem_ack while dmem_req=0 is ignored.

Decomposition:
- Shared defines.v gains:
  - `OPCODE_LD` (6'h18), `OPCODE_ST` (6'h19), `OPCODE_LDR` (6'h1F), if not already present.
  - `IR_NOP`.
  - Memory-stage state encoding (IDLE=1'b0, WAIT=1'b1).
- Optional sub-module `mem_op_decode`: ir -> is_read/is_write. Otherwise single module.

Test Plan:
- Passthrough: ir=ADD, pc=0x100, y=0x3 -> next cycle pc_wb=0x100, ir_wb=ADD, y_wb=0x3; stall_mem never high.
- Zero-wait load: LD, y=0x207, memory acks same cycle with rdata=0xDEADBEEF -> dmem_addr=0x204, dmem_we=0; next cycle y_wb=0xDEADBEEF, stall_count=0.
- Multi-cycle store: ST, y=0x40, st=0x55, ack after 3 cycles:
  - stall_mem high 3 cycles; addr/wdata stable 0x40/0x55 throughout.
  - ir_wb=NOP for 3 cycles, then ST with y_wb=0x40.
  - stall_count=3.
- Back-to-back: LD (2 wait cycles) followed by ADD -> ADD reaches ir_wb exactly one cycle after the LD, no duplicate or loss.
- Reset in WAIT: rst_n=0 on 2nd wait cycle -> dmem_req=0 that cycle; next edge ir_wb=NOP, state IDLE, stall_count=0.
- Saturation (CNT_W=4 override): hold ack low 20 cycles -> stall_count stops at 15.
